// File: rtl/store_buffer.sv
// Store buffer: formats SB/SH/SW requests into word address, lane-replicated data and byte
// enables, queues them in a FIFO and drains to data memory. Optional STORE_BUFFER_LDHAZ_EN.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          st_valid,
  output logic          st_ready,
  input  logic [2:0]    st_sel,
  input  logic [31:0]   st_addr,
  input  logic [31:0]   st_data,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  output logic          st_err,
  output logic [CW-1:0] count,
  output logic          empty
`ifdef STORE_BUFFER_LDHAZ_EN
  ,
  input  logic [31:0]   ld_addr,
  output logic          ld_hazard
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          st_err_q, st_err_d;

  logic [29:0] waddr_q [DEPTH];
  logic [31:0] wdata_q [DEPTH];
  logic [3:0]  be_q    [DEPTH];

  logic        fmt_ok;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata;
  logic        accept, push, pop;

  // Unknown or reserved encodings fall through to the error default.
  always_comb begin
    fmt_ok    = 1'b0;
    fmt_be    = 4'b0000;
    fmt_wdata = 32'h0;
    case (st_sel)
      3'b000: begin
        fmt_ok    = 1'b1;
        fmt_be    = 4'b0001 << st_addr[1:0];
        fmt_wdata = {4{st_data[7:0]}};
      end
      3'b001: begin
        fmt_ok    = ~st_addr[0];
        fmt_be    = st_addr[1] ? 4'b1100 : 4'b0011;
        fmt_wdata = {2{st_data[15:0]}};
      end
      3'b010: begin
        fmt_ok    = (st_addr[1:0] == 2'b00);
        fmt_be    = 4'b1111;
        fmt_wdata = st_data;
      end
      default: fmt_ok = 1'b0;
    endcase
  end

  assign empty     = (count_q == '0);
  assign st_ready  = (count_q != CW'(DEPTH));
  assign mem_valid = ~empty;
  assign count     = count_q;
  assign st_err    = st_err_q;

  assign accept = st_valid & st_ready;
  assign push   = accept & fmt_ok;
  assign pop    = mem_valid & mem_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    st_err_d = accept & ~fmt_ok;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      st_err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      st_err_q <= st_err_d;
    end
  end

  // Payload storage needs no reset: the head is masked to zero whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      waddr_q[wr_ptr_q] <= st_addr[31:2];
      wdata_q[wr_ptr_q] <= fmt_wdata;
      be_q[wr_ptr_q]    <= fmt_be;
    end
  end

  assign mem_addr  = empty ? 32'h0 : {waddr_q[rd_ptr_q], 2'b00};
  assign mem_wdata = empty ? 32'h0 : wdata_q[rd_ptr_q];
  assign mem_be    = empty ? 4'h0  : be_q[rd_ptr_q];

`ifdef STORE_BUFFER_LDHAZ_EN
  logic [PW-1:0] hz_off;
  logic          unused_ld_lsb;

  assign unused_ld_lsb = ^ld_addr[1:0];

  // Entry i is occupied when its distance from the head is below the occupancy count.
  always_comb begin
    hz_off    = '0;
    ld_hazard = push & (st_addr[31:2] == ld_addr[31:2]);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      hz_off = PW'(i) - rd_ptr_q;
      if ((CW'(hz_off) < count_q) && (waddr_q[i] == ld_addr[31:2])) ld_hazard = 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: stimulus pushes expected drains, a monitor pops and compares.
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          st_valid;
  logic          st_ready;
  logic [2:0]    st_sel;
  logic [31:0]   st_addr;
  logic [31:0]   st_data;
  logic          mem_valid;
  logic          mem_ready;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic          st_err;
  logic [CW-1:0] count;
  logic          empty;
`ifdef STORE_BUFFER_LDHAZ_EN
  logic [31:0]   ld_addr;
  logic          ld_hazard;
`endif

  store_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_sel    (st_sel),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .st_err    (st_err),
    .count     (count),
    .empty     (empty)
`ifdef STORE_BUFFER_LDHAZ_EN
    ,
    .ld_addr   (ld_addr),
    .ld_hazard (ld_hazard)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    exp_t e;
    e.addr  = a;
    e.wdata = d;
    e.be    = be;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] d);
    st_sel   = sel;
    st_addr  = a;
    st_data  = d;
    st_valid = 1'b1;
  endtask

  // Monitor: every drain handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && mem_valid && mem_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL drain_unexpected: got addr 0x%08h, required no drain", mem_addr);
      end else begin
        mon_e = sb_q.pop_front();
        chk("drain_addr", mem_addr, mon_e.addr);
        chk("drain_wdata", mem_wdata, mon_e.wdata);
        chk("drain_be", {28'h0, mem_be}, {28'h0, mon_e.be});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    st_valid  = 1'b0;
    st_sel    = 3'b000;
    st_addr   = 32'h0;
    st_data   = 32'h0;
    mem_ready = 1'b0;
`ifdef STORE_BUFFER_LDHAZ_EN
    ld_addr   = 32'h0;
`endif
    tick();
    tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_st_err", 32'(st_err), 32'd0);
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_be", 32'(mem_be), 32'h0);
    rst_n = 1'b1;
    tick();

    // SB into the top lane, drained immediately.
    mem_ready = 1'b1;
    drive(3'b000, 32'h0000_1003, 32'h0000_00A5);
    push_exp(32'h0000_1000, 32'hA5A5_A5A5, 4'b1000);
    #1;
    chk("sb_no_bypass", 32'(mem_valid), 32'd0);
    tick();
    st_valid = 1'b0;
    chk("sb_mem_valid", 32'(mem_valid), 32'd1);
    chk("sb_count", 32'(count), 32'd1);
    chk("sb_st_err", 32'(st_err), 32'd0);
    tick();
    chk("sb_count_after", 32'(count), 32'd0);
    chk("sb_empty_after", 32'(empty), 32'd1);

    // SH upper half, then a misaligned SH.
    drive(3'b001, 32'h0000_2002, 32'h1234_BEEF);
    push_exp(32'h0000_2000, 32'hBEEF_BEEF, 4'b1100);
    tick();
    st_valid = 1'b0;
    chk("sh_count", 32'(count), 32'd1);
    tick();
    chk("sh_count_after", 32'(count), 32'd0);
    drive(3'b001, 32'h0000_2001, 32'h1234_BEEF);
    tick();
    st_valid = 1'b0;
    chk("sh_mis_err", 32'(st_err), 32'd1);
    chk("sh_mis_count", 32'(count), 32'd0);
    chk("sh_mis_mem_valid", 32'(mem_valid), 32'd0);
    tick();
    chk("sh_mis_err_pulse", 32'(st_err), 32'd0);

    // Misaligned SW followed by a reserved encoding: two back-to-back error cycles.
    drive(3'b010, 32'h0000_3001, 32'h1111_2222);
    tick();
    chk("sw_mis_err", 32'(st_err), 32'd1);
    drive(3'b011, 32'h0000_3000, 32'h1111_2222);
    tick();
    st_valid = 1'b0;
    chk("bad_sel_err", 32'(st_err), 32'd1);
    chk("bad_sel_count", 32'(count), 32'd0);
    tick();
    chk("bad_sel_err_end", 32'(st_err), 32'd0);
    chk("bad_sel_mem_valid", 32'(mem_valid), 32'd0);

    // Fill to DEPTH with memory stalled; a fifth request must be held off.
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(3'b010, 32'h10 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
      push_exp(32'h10 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 4'b1111);
      tick();
    end
    drive(3'b010, 32'h0000_0020, 32'hDEAD_DEAD);
    chk("full_count", 32'(count), 32'd4);
    chk("full_st_ready", 32'(st_ready), 32'd0);
    chk("full_head_addr", mem_addr, 32'h0000_0010);
    chk("full_head_wdata", mem_wdata, 32'hC0DE_0000);
    tick();
    st_valid = 1'b0;
    chk("full_hold_count", 32'(count), 32'd4);
    chk("full_hold_addr", mem_addr, 32'h0000_0010);
    mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("drain_count", 32'(count), 32'(3 - k));
    end
    chk("drain_empty", 32'(empty), 32'd1);

    // Simultaneous accept and drain at count 2, across pointer wrap.
    mem_ready = 1'b0;
    drive(3'b010, 32'h0000_0100, 32'h0000_0A01);
    push_exp(32'h0000_0100, 32'h0000_0A01, 4'b1111);
    tick();
    drive(3'b010, 32'h0000_0104, 32'h0000_0A02);
    push_exp(32'h0000_0104, 32'h0000_0A02, 4'b1111);
    tick();
    chk("sim_count_pre", 32'(count), 32'd2);
    mem_ready = 1'b1;
    drive(3'b010, 32'h0000_0108, 32'h0000_0A03);
    push_exp(32'h0000_0108, 32'h0000_0A03, 4'b1111);
    tick();
    chk("sim_count_1", 32'(count), 32'd2);
    drive(3'b001, 32'h0000_010A, 32'h5555_7777);
    push_exp(32'h0000_0108, 32'h7777_7777, 4'b1100);
    tick();
    st_valid = 1'b0;
    chk("sim_count_2", 32'(count), 32'd2);
    tick();
    tick();
    chk("sim_empty", 32'(empty), 32'd1);

    // Full with a same-cycle drain: no push, then reset mid-drain at count 3.
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(3'b010, 32'h200 + 32'(4 * i), 32'hB000_0000 + 32'(i));
      push_exp(32'h200 + 32'(4 * i), 32'hB000_0000 + 32'(i), 4'b1111);
      tick();
    end
    drive(3'b010, 32'h0000_0300, 32'hFFFF_0000);
    mem_ready = 1'b1;
    tick();
    chk("full_drain_no_push", 32'(count), 32'd3);
    rst_n    = 1'b0;
    st_valid = 1'b0;
    sb_q.delete();
    #1;
    chk("rst_mid_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mid_count", 32'(count), 32'd0);
    chk("rst_mid_st_ready", 32'(st_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    drive(3'b010, 32'h0000_0040, 32'h4040_4040);
    push_exp(32'h0000_0040, 32'h4040_4040, 4'b1111);
    tick();
    st_valid = 1'b0;
    chk("post_rst_head", mem_addr, 32'h0000_0040);
    chk("post_rst_count", 32'(count), 32'd1);
    tick();

`ifdef STORE_BUFFER_LDHAZ_EN
    mem_ready = 1'b0;
    ld_addr   = 32'h0000_1000;
    drive(3'b000, 32'h0000_1003, 32'h0000_0011);
    push_exp(32'h0000_1000, 32'h1111_1111, 4'b1000);
    #1;
    chk("hz_accept", 32'(ld_hazard), 32'd1);
    tick();
    st_valid = 1'b0;
    chk("hz_pending", 32'(ld_hazard), 32'd1);
    ld_addr = 32'h0000_1004;
    #1;
    chk("hz_other_word", 32'(ld_hazard), 32'd0);
    ld_addr = 32'h0000_1002;
    #1;
    chk("hz_same_word", 32'(ld_hazard), 32'd1);
    mem_ready = 1'b1;
    tick();
    chk("hz_after_drain", 32'(ld_hazard), 32'd0);
`endif

    for (int w = 0; w < 20 && sb_q.size() != 0; w++) tick();
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Store-side companion to the load extract/sign-extend path. Takes SB/SH/SW requests from the MEM stage and turns each into a word-aligned address, a replicated write word and a 4-bit byte-enable.
- Queues requests in a small FIFO and drains them to data memory over a valid/ready handshake.
- The pipeline stalls only when the buffer is full. Illegal or misaligned stores are flagged and dropped.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, >= 2.
- CW, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- st_valid  in  1  store request valid.
- st_ready  out  1  buffer can accept a request.
- st_sel  in  3  store type, funct3 encoding: 000 SB, 001 SH, 010 SW.
- st_addr  in  32  byte address.
- st_data  in  32  rs2 data; low byte/half/word is used.
- mem_valid  out  1  head entry valid toward data memory.
- mem_ready  in  1  data memory accepts the head entry.
- mem_addr  out  32  {addr[31:2],2'b00} of the head entry.
- mem_wdata  out  32  replicated write data of the head entry.
- mem_be  out  4  byte enables of the head entry; bit i enables byte lane i, i.e. bits [8i+7:8i].
- st_err  out  1  one-cycle pulse: previous-cycle request was illegal or misaligned.
- count  out  CW  number of occupied entries.
- empty  out  1  count == 0.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - Pointers and count go to 0; empty=1.
  - mem_valid=0, st_err=0.
  - mem_addr, mem_wdata and mem_be read 0 while empty.
  - Entries in flight are discarded, including during a handshake.
- Handshakes:
  - Accept = st_valid & st_ready. st_ready = (count != DEPTH).
  - Drain = mem_valid & mem_ready. mem_valid = !empty.
- Formatting, computed combinationally at accept and stored in the entry:
  - SB: be = 4'b0001 << addr[1:0]; wdata = {4{data[7:0]}}.
  - SH: requires addr[0]==0. be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{data[15:0]}}.
  - SW: requires addr[1:0]==0. be = 4'b1111; wdata = data.
- Errors:
  - Any other st_sel value, or a misaligned SH/SW, is an error.
  - The handshake still completes: st_ready is unaffected and the request is consumed.
  - Nothing is enqueued and count is unchanged.
  - st_err goes high for exactly the following cycle.
- Latency:
  - An accepted entry is visible on the mem_* outputs in the cycle after accept. There is no combinational bypass, even when empty.
  - The head is read directly from storage, so mem_* are stable while mem_valid=1 and mem_ready=0.
- Ordering: strict FIFO. Pointers wrap modulo DEPTH.
- Simultaneous accept and drain:
  - count is unchanged.
  - When full, st_ready=0, so a same-cycle drain does not allow a push that cycle.
- Full: st_ready deasserts in the cycle after the DEPTH-th accept, provided no drain occurred.
- Empty: a drain cannot occur. mem_ready is ignored while mem_valid=0.
- Unknown st_sel is treated as an error, never as X propagation.

Optional Feature:
- Macro STORE_BUFFER_LDHAZ_EN. When defined, adds two ports:
  - ld_addr  in  32  load byte address from MEM.
  - ld_hazard  out  1  combinational.
- ld_hazard=1 when any occupied entry's word address equals ld_addr[31:2], or when an accept to that word is in progress this cycle. The pipeline stalls the load while ld_hazard=1.
- When the macro is not defined, these ports do not exist and no comparators are built.

Test Plan:
- SB, addr 0x0000_1003, data 0x0000_00A5, mem_ready=1 -> next cycle: mem_valid=1, mem_addr=0x0000_1000, mem_be=4'b1000, mem_wdata=0xA5A5_A5A5; count returns to 0 after the drain.
- SH, addr 0x0000_2002, data 0x1234_BEEF -> mem_be=4'b1100, mem_wdata=0xBEEF_BEEF. SH at 0x0000_2001 -> st_err pulse for 1 cycle; count stays 0; mem_valid stays 0.
- SW at 0x0000_3001, then st_sel=3'b011 at 0x0000_3000 -> st_err high for 2 consecutive cycles; nothing enqueued.
- mem_ready=0, four SW to 0x10/0x14/0x18/0x1C -> count=4, st_ready=0, mem_* held at entry 0x10. Then mem_ready=1 -> drains 0x10, 0x14, 0x18, 0x1C on 4 consecutive cycles; empty=1 after.
- count=2, accept and drain in the same cycle -> count stays 2; FIFO order preserved across pointer wrap.
- rst_n low mid-drain with count=3 -> immediately: mem_valid=0, count=0, st_ready=1. After release, the next SW to 0x40 is the head.
- With STORE_BUFFER_LDHAZ_EN: pending SB at 0x0000_1003, ld_addr=0x0000_1000 -> ld_hazard=1. With ld_addr=0x0000_1004 -> ld_hazard=0.
